accel_g_scaler: RTL

Multi-channel, parametrised accelerometer g-value scaler. It converts up to NUM_CH signed raw axis readings into scaled "g" magnitudes with sign, using an internal restoring serial divider (no divider IP core). It sits between the accelerometer SPI capture logic and the display/BCD and motion-control consumers. Each start request converts one snapshot of all channels and publishes the results atomically.

---
 rtl/accel_g_scaler_if.sv | 16 +
 rtl/accel_g_scaler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/accel_g_scaler_if.sv
// Start/snapshot request and published result bus of the g-value scaler.
interface accel_g_scaler_if #(
    parameter int DIN_W  = 10,
    parameter int NUM_CH = 3,
    parameter int QUO_W  = 9
);
    logic                          start;
    logic [NUM_CH*DIN_W-1:0]       din;
    logic                          busy;
    logic                          done;
    logic [NUM_CH*(QUO_W+1)-1:0]   acc_out;
    logic [NUM_CH-1:0]             sat;

    modport master (output start, din, input busy, done, acc_out, sat);
    modport slave  (input start, din, output busy, done, acc_out, sat);
endinterface

// File: rtl/accel_g_scaler.sv
// Purpose: scales NUM_CH raw accelerometer axes to signed g magnitudes via a restoring serial divider.
// Latency: NUM_CH*(DVD_W+2)+1 cycles from start to done, independent of data.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module accel_g_scaler #(
    parameter int DIN_W         = 10,
    parameter int NUM_CH        = 3,
    parameter int SCALING_SHIFT = 6,
    parameter int DIVISOR_W     = 8,
    parameter int DIVISOR       = 163,
    parameter int QUO_W         = 9,
    parameter int TWOS_COMP     = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    accel_g_scaler_if.slave       bus
);
    localparam int MAG_W = DIN_W - 1;
    localparam int DVD_W = DIN_W - 1 + SCALING_SHIFT;
    localparam int OUT_W = QUO_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [DIVISOR_W-1:0] DIV_C = DIVISOR_W'(DIVISOR);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_STORE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH*DIN_W-1:0]   din_q, din_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DVD_W-1:0]          dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]      rem_q, rem_d;
    logic                      sign_q, sign_d;
    logic                      msat_q, msat_d;
    logic [NUM_CH*OUT_W-1:0]   shd_acc_q, shd_acc_d;
    logic [NUM_CH-1:0]         shd_sat_q, shd_sat_d;
    logic [NUM_CH*OUT_W-1:0]   acc_q, acc_d;
    logic [NUM_CH-1:0]         sat_q, sat_d;

    logic [DIN_W-1:0]          raw;
    logic [MAG_W-1:0]          mag;
    logic [DIVISOR_W:0]        trial;
    logic                      ovf;
    logic [QUO_W-1:0]          q_mag;
    logic                      q_sign;

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        sign_d    = sign_q;
        msat_d    = msat_q;
        shd_acc_d = shd_acc_q;
        shd_sat_d = shd_sat_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        mag       = '0;
        raw       = din_q[int'(ch_q)*DIN_W +: DIN_W];
        trial     = {rem_q, dvd_q[DVD_W-1]};
        // dvd_q holds the finished quotient once the DIV phase has shifted it in
        ovf       = ({{QUO_W{1'b0}}, dvd_q} > {{DVD_W{1'b0}}, {QUO_W{1'b1}}});
        q_mag     = ovf ? '1 : QUO_W'(dvd_q);
        q_sign    = sign_q & (q_mag != '0);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    din_d   = bus.din;
                    ch_d    = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_d = raw[DIN_W-1];
                msat_d = 1'b0;
                if (TWOS_COMP != 0) begin
                    if (raw == {1'b1, {MAG_W{1'b0}}}) begin
                        mag    = '1;
                        msat_d = 1'b1;
                    end else if (raw[DIN_W-1]) begin
                        // |raw| fits in MAG_W bits for every code but the most-negative one
                        mag = ~raw[MAG_W-1:0] + MAG_W'(1);
                    end else begin
                        mag = raw[MAG_W-1:0];
                    end
                end else begin
                    mag = raw[MAG_W-1:0];
                end
                dvd_d   = DVD_W'(mag) << SCALING_SHIFT;
                rem_d   = '0;
                cnt_d   = CNT_W'(DVD_W);
                state_d = S_DIV;
            end
            S_DIV: begin
                if (trial >= {1'b0, DIV_C}) begin
                    rem_d = trial[DIVISOR_W-1:0] - DIV_C;
                    dvd_d = {dvd_q[DVD_W-2:0], 1'b1};
                end else begin
                    rem_d = trial[DIVISOR_W-1:0];
                    dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                shd_acc_d[int'(ch_q)*OUT_W +: OUT_W] = {q_sign, q_mag};
                shd_sat_d[ch_q]                       = ovf | msat_q;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    // publish on entry to DONE so results are visible alongside the done pulse
                    acc_d   = shd_acc_d;
                    sat_d   = shd_sat_d;
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            din_q     <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            sign_q    <= 1'b0;
            msat_q    <= 1'b0;
            shd_acc_q <= '0;
            shd_sat_q <= '0;
            acc_q     <= '0;
            sat_q     <= '0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            sign_q    <= sign_d;
            msat_q    <= msat_d;
            shd_acc_q <= shd_acc_d;
            shd_sat_q <= shd_sat_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.acc_out = acc_q;
    assign bus.sat     = sat_q;

endmodule
